// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional combinational response-to-decode path is enabled with FETCH_BYPASS_EN.
package instr_fetch_unit_pkg;

    localparam int XLEN        = 32;
    localparam int FETCH_DEPTH = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_s;

    typedef enum logic [1:0] {
        S_INIT,
        S_FETCH,
        S_DRAIN
    } fetch_state_e;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory, execute redirect and decode.
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    // Handshakes: a transfer happens on a cycle where valid && ready; the producer
    // keeps valid and payload stable until then, except that a fetch request may be
    // withdrawn in a redirect cycle. Memory responses have no ready and must be taken.
    logic            i_redirect_valid;
    logic [XLEN-1:0] i_redirect_pc;
    logic            o_mem_req_valid;
    logic            i_mem_req_ready;
    logic [XLEN-1:0] o_mem_req_addr;
    logic            i_mem_rsp_valid;
    logic [XLEN-1:0] i_mem_rsp_data;
    logic            o_instr_valid;
    logic            i_instr_ready;
    logic [XLEN-1:0] o_instruction;
    logic [XLEN-1:0] o_pc;

    modport master (
        input  i_redirect_valid, i_redirect_pc, i_mem_req_ready,
        input  i_mem_rsp_valid, i_mem_rsp_data, i_instr_ready,
        output o_mem_req_valid, o_mem_req_addr, o_instr_valid, o_instruction, o_pc
    );

    modport slave (
        output i_redirect_valid, i_redirect_pc, i_mem_req_ready,
        output i_mem_rsp_valid, i_mem_rsp_data, i_instr_ready,
        input  o_mem_req_valid, o_mem_req_addr, o_instr_valid, o_instruction, o_pc
    );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch queue of {pc, instruction} entries; flush wins over push and pop.
module instr_fetch_unit_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  fetch_entry_s           i_entry,
    output fetch_entry_s           o_head,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_s   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_push, do_pop;

    assign do_pop  = i_pop && (count_q != '0);
    assign do_push = i_push && ((count_q != (AW+1)'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage is reset so the decode-facing outputs read zero out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push && !i_flush) mem_q[wr_ptr_q] <= i_entry;
        end
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_empty = (count_q == '0);
    assign o_count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetcher with credit-limited requests, prefetch queue and redirect drain.
// Define FETCH_BYPASS_EN to forward a live response straight to decode when the queue is empty.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              DEPTH    = FETCH_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    instr_fetch_unit_if.master  bus,
    output fetch_state_e        dbg_state_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   stale_q, stale_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    fetch_entry_s    fifo_head, push_entry;
    logic [CW-1:0]   live_outstanding;
    logic [CW:0]     credit_used;
    logic            redirect, req_valid, req_fire, rsp_accept, rsp_live, push, pop;

    assign redirect         = bus.i_redirect_valid;
    assign live_outstanding = outstanding_q - stale_q;
    assign credit_used      = {1'b0, fifo_count} + {1'b0, live_outstanding};

    // Queue entries plus live fetches in flight never exceed DEPTH, so pushes always fit.
    assign req_valid  = (state_q != S_INIT) && (credit_used < (CW+1)'(DEPTH))
                        && (outstanding_q < CW'(DEPTH));
    assign req_fire   = req_valid && bus.i_mem_req_ready;
    assign rsp_accept = bus.i_mem_rsp_valid && (outstanding_q != '0);
    assign rsp_live   = rsp_accept && (stale_q == '0) && !redirect;

    always_comb begin
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_accept);
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        stale_d       = stale_q;
        if (redirect) begin
            fetch_pc_d = bus.i_redirect_pc;
            rsp_pc_d   = bus.i_redirect_pc;
            stale_d    = outstanding_d;
        end else begin
            if (req_fire) fetch_pc_d = next_pc(fetch_pc_q);
            if (rsp_live) rsp_pc_d = next_pc(rsp_pc_q);
            if (rsp_accept && (stale_q != '0)) stale_d = stale_q - CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH, S_DRAIN: begin
                if (redirect) state_d = (stale_d != '0) ? S_DRAIN : S_FETCH;
                else if ((state_q == S_DRAIN) && (stale_d == '0)) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_INIT;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            stale_q       <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
        end
    end

    assign push_entry = '{pc: rsp_pc_q, instr: bus.i_mem_rsp_data};
    assign pop        = !fifo_empty && !redirect && bus.i_instr_ready;

`ifdef FETCH_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit        = fifo_empty && rsp_live;
    assign push              = rsp_live && !(bypass_hit && bus.i_instr_ready);
    assign bus.o_instr_valid = (!fifo_empty || bypass_hit) && !redirect;
    assign bus.o_instruction = bypass_hit ? bus.i_mem_rsp_data : fifo_head.instr;
    assign bus.o_pc          = bypass_hit ? rsp_pc_q : fifo_head.pc;
`else
    assign push              = rsp_live;
    assign bus.o_instr_valid = !fifo_empty && !redirect;
    assign bus.o_instruction = fifo_head.instr;
    assign bus.o_pc          = fifo_head.pc;
`endif

    instr_fetch_unit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_pop   (pop),
        .i_flush (redirect),
        .i_entry (push_entry),
        .o_head  (fifo_head),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    assign bus.o_mem_req_valid = req_valid;
    assign bus.o_mem_req_addr  = fetch_pc_q;
    assign dbg_state_o         = state_q;

endmodule
